lcd_timing: RTL and testbench

- Free-running raster timing generator for the parallel-RGB LCD.
- Produces pixel coordinates x/y for the downstream pixel-colour stage (test pattern or character renderer), plus hsync, vsync and data-enable for the panel.
- Sync/DE outputs pass through a configurable delay line so they line up with colour data from a stage that has PIPE_DELAY cycles of latency (font ROM lookup = 1).

---
 rtl/lcd_timing.sv | 124 ++++++++++++
 tb/tb_lcd_timing.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing.sv
// Free-running raster timing generator for a parallel-RGB LCD panel.
// Sync and data-enable go through a short delay line to line up with the colour pipeline.
module lcd_timing #(
  parameter int H_ACTIVE        = 800,
  parameter int H_FRONT         = 40,
  parameter int H_SYNC          = 48,
  parameter int H_BACK          = 40,
  parameter int V_ACTIVE        = 480,
  parameter int V_FRONT         = 13,
  parameter int V_SYNC          = 3,
  parameter int V_BACK          = 29,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int PIPE_DELAY      = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic       de
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FRONT + V_SYNC);

  if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_min
    $error("lcd_timing: every timing parameter must be at least 1");
  end
  if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_bad_total
    $error("lcd_timing: H_TOTAL and V_TOTAL must not exceed 2047");
  end
  if (H_ACTIVE > 1024 || V_ACTIVE > 1024) begin : g_bad_active
    $error("lcd_timing: active region must fit the 10-bit x/y outputs");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_delay
    $error("lcd_timing: PIPE_DELAY must be in 0..7");
  end

  logic [10:0] h_count;
  logic [10:0] v_count;
  logic        h_last;
  logic        v_last;
  logic        act;
  logic        hs;
  logic        vs;
  logic [2:0]  dly_out;

  assign h_last = (h_count == H_LAST);
  assign v_last = (v_count == V_LAST);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      h_count <= '0;
    end else if (h_last) begin
      h_count <= '0;
    end else begin
      h_count <= h_count + 11'd1;
    end
  end

  // The line counter only moves when a line ends, so vs changes only at h_count = 0.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      v_count <= '0;
    end else if (h_last) begin
      if (v_last) begin
        v_count <= '0;
      end else begin
        v_count <= v_count + 11'd1;
      end
    end
  end

  always_comb begin
    act = (h_count < H_ACT_END) && (v_count < V_ACT_END);
    hs  = (h_count >= HS_START) && (h_count < HS_END);
    vs  = (v_count >= VS_START) && (v_count < VS_END);
  end

  assign x           = act ? h_count[9:0] : 10'd0;
  assign y           = act ? v_count[9:0] : 10'd0;
  assign active      = act;
  assign frame_start = (h_count == 11'd0) && (v_count == 11'd0);

  // Reset clears every stage at once so stale sync/DE from an aborted frame never reaches the panel.
  if (PIPE_DELAY == 0) begin : g_no_delay
    assign dly_out = {hs, vs, act};
  end else begin : g_delay
    logic [2:0] pipe [PIPE_DELAY];

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        for (int i = 0; i < PIPE_DELAY; i++) begin
          pipe[i] <= 3'b000;
        end
      end else begin
        pipe[0] <= {hs, vs, act};
        for (int i = 1; i < PIPE_DELAY; i++) begin
          pipe[i] <= pipe[i-1];
        end
      end
    end

    assign dly_out = pipe[PIPE_DELAY-1];
  end

  assign hsync = dly_out[2] ^ SYNC_ACTIVE_LOW;
  assign vsync = dly_out[1] ^ SYNC_ACTIVE_LOW;
  assign de    = dly_out[0];

endmodule

// File: tb/tb_lcd_timing.sv
// Self-checking bench for lcd_timing: a frame-position model checks every cycle,
// directed literal checks pin reset, line/frame boundaries and mid-frame reset.
module tb_lcd_timing;

  localparam int HA = 8, HF = 2, HS = 3, HB = 1;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] x_o  [4];
  logic [9:0] y_o  [4];
  logic       act_o[4];
  logic       fs_o [4];
  logic       hs_o [4];
  logic       vs_o [4];
  logic       de_o [4];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Instance 0: delay 1, active-low sync; 1: delay 0; 2: delay 3; 3: delay 1, active-high sync.
  lcd_timing #(.H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
               .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
               .SYNC_ACTIVE_LOW(1'b1), .PIPE_DELAY(1)) dut (
    .clock(clock), .reset_n(reset_n), .x(x_o[0]), .y(y_o[0]), .active(act_o[0]),
    .frame_start(fs_o[0]), .hsync(hs_o[0]), .vsync(vs_o[0]), .de(de_o[0]));

  lcd_timing #(.H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
               .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
               .SYNC_ACTIVE_LOW(1'b1), .PIPE_DELAY(0)) dut_pd0 (
    .clock(clock), .reset_n(reset_n), .x(x_o[1]), .y(y_o[1]), .active(act_o[1]),
    .frame_start(fs_o[1]), .hsync(hs_o[1]), .vsync(vs_o[1]), .de(de_o[1]));

  lcd_timing #(.H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
               .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
               .SYNC_ACTIVE_LOW(1'b1), .PIPE_DELAY(3)) dut_pd3 (
    .clock(clock), .reset_n(reset_n), .x(x_o[2]), .y(y_o[2]), .active(act_o[2]),
    .frame_start(fs_o[2]), .hsync(hs_o[2]), .vsync(vs_o[2]), .de(de_o[2]));

  lcd_timing #(.H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
               .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
               .SYNC_ACTIVE_LOW(1'b0), .PIPE_DELAY(1)) dut_hi (
    .clock(clock), .reset_n(reset_n), .x(x_o[3]), .y(y_o[3]), .active(act_o[3]),
    .frame_start(fs_o[3]), .hsync(hs_o[3]), .vsync(vs_o[3]), .de(de_o[3]));

  function automatic int dly(input int i);
    case (i)
      1:       return 0;
      2:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic logic pol(input int i);
    return (i != 3);
  endfunction

  // Raw {hs, vs, act} for a position counted in pixels from the start of the frame.
  function automatic logic [2:0] raw(input int c);
    int   h;
    int   v;
    logic a;
    logic hh;
    logic vv;
    h  = c % HT;
    v  = c / HT;
    a  = (h < HA) && (v < VA);
    hh = (h >= HA + HF) && (h < HA + HF + HS);
    vv = (v >= VA + VF) && (v < VA + VF + VS);
    return {hh, vv, a};
  endfunction

  int         cnt   = 0;
  int         edges = 0;
  logic [2:0] hist[8];

  always @(posedge clock) begin
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = reset_n ? raw(cnt) : 3'b000;
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) hist[i] = 3'b000;
    end
    cnt = reset_n ? (cnt + 1) % FT : 0;
    edges++;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst_val, input int cycles);
    reset_n = rst_val;
    repeat (cycles) @(posedge clock);
    @(negedge clock);
  endtask

  always @(negedge clock) begin
    int         h;
    int         v;
    logic       a;
    logic [2:0] e;
    if (edges >= 3) begin
      h = cnt % HT;
      v = cnt / HT;
      a = (h < HA) && (v < VA);
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("model_x[%0d]", i), int'(x_o[i]), a ? h : 0);
        checkOutput($sformatf("model_y[%0d]", i), int'(y_o[i]), a ? v : 0);
        checkOutput($sformatf("model_active[%0d]", i), int'(act_o[i]), int'(a));
        checkOutput($sformatf("model_fs[%0d]", i), int'(fs_o[i]), int'(cnt == 0));
        if (dly(i) == 0 && !reset_n) continue;
        e = (dly(i) == 0) ? raw(cnt) : hist[dly(i)-1];
        checkOutput($sformatf("model_hsync[%0d]", i), int'(hs_o[i]), int'(e[2] ^ pol(i)));
        checkOutput($sformatf("model_vsync[%0d]", i), int'(vs_o[i]), int'(e[1] ^ pol(i)));
        checkOutput($sformatf("model_de[%0d]", i), int'(de_o[i]), int'(e[0]));
      end
    end
  end

  initial begin
    int n;
    $display("[TB] lcd_timing bench start");

    applyStimulus(1'b0, 5);
    checkOutput("rst_hsync", int'(hs_o[0]), 1);
    checkOutput("rst_vsync", int'(vs_o[0]), 1);
    checkOutput("rst_de", int'(de_o[0]), 0);
    checkOutput("rst_x", int'(x_o[0]), 0);
    checkOutput("rst_y", int'(y_o[0]), 0);
    checkOutput("rst_fs", int'(fs_o[0]), 1);
    checkOutput("rst_hsync_hi", int'(hs_o[3]), 0);
    checkOutput("rst_vsync_hi", int'(vs_o[3]), 0);

    applyStimulus(1'b1, 1);
    checkOutput("rel_x", int'(x_o[0]), 1);
    checkOutput("rel_fs", int'(fs_o[0]), 0);

    applyStimulus(1'b1, 6);
    checkOutput("h7_x", int'(x_o[0]), 7);
    checkOutput("h7_active", int'(act_o[0]), 1);
    checkOutput("h7_de", int'(de_o[0]), 1);
    checkOutput("h7_de_pd0", int'(de_o[1]), 1);

    applyStimulus(1'b1, 1);
    checkOutput("h8_x", int'(x_o[0]), 0);
    checkOutput("h8_active", int'(act_o[0]), 0);
    checkOutput("h8_de", int'(de_o[0]), 1);
    checkOutput("h8_de_pd0", int'(de_o[1]), 0);
    checkOutput("h8_de_pd3", int'(de_o[2]), 1);

    applyStimulus(1'b1, 1);
    checkOutput("h9_de", int'(de_o[0]), 0);

    applyStimulus(1'b1, 2);
    checkOutput("h11_hsync", int'(hs_o[0]), 0);
    checkOutput("h11_hsync_hi", int'(hs_o[3]), 1);
    checkOutput("h11_de_pd3", int'(de_o[2]), 0);

    applyStimulus(1'b1, 2);
    checkOutput("h13_hsync", int'(hs_o[0]), 0);

    applyStimulus(1'b1, 1);
    checkOutput("v1_y", int'(y_o[0]), 1);
    checkOutput("v1_x", int'(x_o[0]), 0);
    checkOutput("v1_hsync", int'(hs_o[0]), 1);

    for (int k = 0; k < 200; k++) begin
      if (fs_o[0]) break;
      applyStimulus(1'b1, 1);
    end
    checkOutput("fs_found", int'(fs_o[0]), 1);

    applyStimulus(1'b1, 1);
    n = 1;
    checkOutput("fs_width", int'(fs_o[0]), 0);
    while (!fs_o[0] && n < 200) begin
      applyStimulus(1'b1, 1);
      n++;
    end
    checkOutput("fs_period", n, FT);

    applyStimulus(1'b1, 70);
    checkOutput("v5h0_vsync", int'(vs_o[0]), 1);
    applyStimulus(1'b1, 1);
    checkOutput("v5h1_vsync", int'(vs_o[0]), 0);
    checkOutput("v5h1_vsync_hi", int'(vs_o[3]), 1);
    checkOutput("v5h1_y", int'(y_o[0]), 0);

    applyStimulus(1'b1, 74);
    checkOutput("mid_x", int'(x_o[0]), 5);
    checkOutput("mid_y", int'(y_o[0]), 2);
    checkOutput("mid_de_pd3", int'(de_o[2]), 1);

    applyStimulus(1'b0, 1);
    checkOutput("midrst_fs", int'(fs_o[0]), 1);
    checkOutput("midrst_x", int'(x_o[0]), 0);
    checkOutput("midrst_de", int'(de_o[0]), 0);
    checkOutput("midrst_de_pd3", int'(de_o[2]), 0);
    checkOutput("midrst_hsync", int'(hs_o[0]), 1);

    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 1);
    checkOutput("midrel_x", int'(x_o[0]), 1);
    checkOutput("midrel_y", int'(y_o[0]), 0);
    checkOutput("midrel_fs", int'(fs_o[0]), 0);
    checkOutput("midrel_de", int'(de_o[0]), 1);
    checkOutput("midrel_de_pd3", int'(de_o[2]), 0);

    applyStimulus(1'b1, 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
